calc_alu_sequencer: RTL and testbench

//  Calculator op controller. Accepts one (a, b, op) request via valid/ready and

---
 rtl/calc_alu_sequencer_pkg.sv | 19 +
 rtl/calc_alu_sequencer_addsub_unit.sv | 16 +
 rtl/calc_alu_sequencer.sv | 167 ++++++++++++++++
 tb/tb_calc_alu_sequencer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/calc_alu_sequencer_pkg.sv
// Shared definitions for the calculator op sequencer: op codes and FSM states.
package calc_alu_sequencer_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC_AS,
      S_EXEC_MUL,
      S_EXEC_DIV,
      S_DONE
   } state_e;

endpackage

// File: rtl/calc_alu_sequencer_addsub_unit.sv
// Combinational W-bit adder/subtractor shared by every calculator op.
module calc_addsub_unit #(
   parameter int W = 5
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         sub,
   output logic [W-1:0] s,
   output logic         co
);

   always_comb begin
      {co, s} = {1'b0, x} + {1'b0, y ^ {W{sub}}} + {{W{1'b0}}, sub};
   end

endmodule

// File: rtl/calc_alu_sequencer.sv
// Calculator op controller: one request at a time, all arithmetic time-shared
// through a single add/subtract unit (ADD/SUB one pass, MUL/DIV WIDTH passes).
module calc_alu_sequencer
   import calc_alu_sequencer_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 cout,
   output logic                 err,
   output logic                 busy
);

   localparam int RES_W = 2 * WIDTH;
   localparam int CNT_W = $clog2(WIDTH + 1);

   state_e             state, state_nxt;
   op_e                op_r;
   logic [WIDTH-1:0]   a_r, b_r;
   logic [WIDTH-1:0]   acc, quo;
   logic [WIDTH-1:0]   acc_nxt, quo_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH:0]     rem_sh;
   logic               accept, last;

   logic [WIDTH:0]     au_x, au_y, au_s;
   logic               au_sub, au_co;

   calc_addsub_unit #(.W(WIDTH + 1)) u_addsub (
      .x   (au_x),
      .y   (au_y),
      .sub (au_sub),
      .s   (au_s),
      .co  (au_co)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // acc/quo double as {P_hi, P_lo} for MUL and {remainder, quotient} for DIV.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      au_x      = '0;
      au_y      = '0;
      au_sub    = 1'b0;
      acc_nxt   = acc;
      quo_nxt   = quo;
      rem_sh    = {acc, quo[WIDTH-1]};
      last      = (cnt == CNT_W'(WIDTH - 1));
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept = 1'b1;
               case (op_e'(op))
                  OP_ADD, OP_SUB: state_nxt = S_EXEC_AS;
                  OP_MUL:         state_nxt = S_EXEC_MUL;
                  default:        state_nxt = (b == '0) ? S_DONE : S_EXEC_DIV;
               endcase
            end
         end
         S_EXEC_AS: begin
            busy      = 1'b1;
            au_x      = {1'b0, a_r};
            au_y      = {1'b0, b_r};
            au_sub    = (op_r == OP_SUB);
            state_nxt = S_DONE;
         end
         S_EXEC_MUL: begin
            busy    = 1'b1;
            au_x    = {1'b0, acc};
            au_y    = quo[0] ? {1'b0, a_r} : '0;
            acc_nxt = au_s[WIDTH:1];
            quo_nxt = {au_s[0], quo[WIDTH-1:1]};
            if (last) state_nxt = S_DONE;
         end
         S_EXEC_DIV: begin
            busy   = 1'b1;
            au_x   = rem_sh;
            au_y   = {1'b0, b_r};
            au_sub = 1'b1;
            if (au_co) begin
               acc_nxt = au_s[WIDTH-1:0];
               quo_nxt = {quo[WIDTH-2:0], 1'b1};
            end else begin
               acc_nxt = rem_sh[WIDTH-1:0];
               quo_nxt = {quo[WIDTH-2:0], 1'b0};
            end
            if (last) state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_r   <= OP_ADD;
         a_r    <= '0;
         b_r    <= '0;
         acc    <= '0;
         quo    <= '0;
         cnt    <= '0;
         result <= '0;
         cout   <= 1'b0;
         err    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_r <= op_e'(op);
                  a_r  <= a;
                  b_r  <= b;
                  acc  <= '0;
                  quo  <= (op_e'(op) == OP_DIV) ? a : b;
                  cnt  <= '0;
                  if (op_e'(op) == OP_DIV && b == '0) begin
                     result <= '1;
                     cout   <= 1'b0;
                     err    <= 1'b1;
                  end
               end
            end
            S_EXEC_AS: begin
               err <= 1'b0;
               if (op_r == OP_SUB) begin
                  result <= {{(WIDTH - 1){au_s[WIDTH]}}, au_s};
                  cout   <= au_co;
               end else begin
                  result <= RES_W'(au_s);
                  cout   <= au_s[WIDTH];
               end
            end
            S_EXEC_MUL, S_EXEC_DIV: begin
               acc <= acc_nxt;
               quo <= quo_nxt;
               cnt <= cnt + 1'b1;
               if (last) begin
                  result <= {acc_nxt, quo_nxt};
                  cout   <= 1'b0;
                  err    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Directed-vector bench for calc_alu_sequencer with hand-computed expectations.
module tb_calc_alu_sequencer;

   localparam int WIDTH = 4;
   localparam int RES_W = 2 * WIDTH;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic [WIDTH-1:0] a, b;
   logic             out_valid;
   logic             out_ready;
   logic [RES_W-1:0] result;
   logic             cout, err, busy;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   calc_alu_sequencer #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, measure accept-to-out_valid edges and busy cycles, check
   // the result, then release it with out_ready.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [3:0] va,
                         input logic [3:0] vb, input int lat, input int nbusy,
                         input logic [7:0] res, input logic c, input logic e);
      int edges, busy_cnt, guard;
      guard = 0;
      while (!in_ready && guard < 20) begin
         tick();
         guard++;
      end
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      op = o; a = va; b = vb; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = ~va; b = ~vb; op = ~o;
      edges = 1;
      busy_cnt = busy ? 1 : 0;
      while (!out_valid && edges < 20) begin
         tick();
         edges++;
         if (busy) busy_cnt++;
      end
      check({tag, "_latency"}, 32'(edges), 32'(lat));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(nbusy));
      check({tag, "_result"}, 32'(result), 32'(res));
      check({tag, "_cout"}, 32'(cout), 32'(c));
      check({tag, "_err"}, 32'(err), 32'(e));
      check({tag, "_ready_in_done"}, 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_released"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op = 2'b00; a = '0; b = '0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'h00);
      check("rst_err", 32'(err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      tick();
      check("idle_out_valid", 32'(out_valid), 32'd0);

      run_op("add_2_8", 2'b00, 4'h2, 4'h8, 2, 1, 8'h0A, 1'b0, 1'b0);
      run_op("add_f_1", 2'b00, 4'hF, 4'h1, 2, 1, 8'h10, 1'b1, 1'b0);
      run_op("add_f_f", 2'b00, 4'hF, 4'hF, 2, 1, 8'h1E, 1'b1, 1'b0);
      run_op("sub_2_7", 2'b01, 4'h2, 4'h7, 2, 1, 8'hFB, 1'b0, 1'b0);
      run_op("sub_7_2", 2'b01, 4'h7, 4'h2, 2, 1, 8'h05, 1'b1, 1'b0);
      run_op("sub_5_5", 2'b01, 4'h5, 4'h5, 2, 1, 8'h00, 1'b1, 1'b0);
      run_op("mul_f_f", 2'b10, 4'hF, 4'hF, 5, 4, 8'hE1, 1'b0, 1'b0);
      run_op("mul_0_9", 2'b10, 4'h0, 4'h9, 5, 4, 8'h00, 1'b0, 1'b0);
      run_op("mul_6_7", 2'b10, 4'h6, 4'h7, 5, 4, 8'h2A, 1'b0, 1'b0);
      run_op("div_d_3", 2'b11, 4'hD, 4'h3, 5, 4, 8'h14, 1'b0, 1'b0);
      run_op("div_5_0", 2'b11, 4'h5, 4'h0, 1, 0, 8'hFF, 1'b0, 1'b1);
      run_op("div_f_1", 2'b11, 4'hF, 4'h1, 5, 4, 8'h0F, 1'b0, 1'b0);
      run_op("div_3_7", 2'b11, 4'h3, 4'h7, 5, 4, 8'h30, 1'b0, 1'b0);

      // Hold DONE for 10 cycles with a competing request that must be ignored.
      op = 2'b00; a = 4'h9; b = 4'h4; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result0", 32'(result), 32'h0D);
      op = 2'b10; a = 4'h3; b = 4'h3; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("hold_result", 32'(result), 32'h0D);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_out_valid", 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("hold_released", 32'(in_ready), 32'd1);

      // Reset in the middle of a multiply discards it.
      op = 2'b10; a = 4'hB; b = 4'hD; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      check("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_result", 32'(result), 32'h00);
      for (int i = 0; i < 6; i++) begin
         check("mid_rst_no_valid", 32'(out_valid), 32'd0);
         tick();
      end
      run_op("post_rst_add", 2'b00, 4'h3, 4'h4, 2, 1, 8'h07, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
